// File: rtl/video_wr_scheduler.sv
// rtl/video_wr_scheduler.sv - in-order CPU-to-video write queue with frame-synchronised update window
module video_wr_scheduler #(
    parameter int DEPTH      = 16,
    parameter int WIN_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cpu_cs,
    input  logic                       cpu_wr,
    input  logic [20:0]                cpu_addr,
    input  logic [31:0]                cpu_wr_data,
    input  logic                       defer_en,
    input  logic                       frame_end,
    input  logic                       clr_overflow,
    output logic                       video_cs,
    output logic                       video_wr,
    output logic [20:0]                video_addr,
    output logic [31:0]                video_wr_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       fifo_full,
    output logic                       overflow,
    output logic                       in_window
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WIN_CYCLES + 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [CW-1:0] WIN_LOAD = CW'(WIN_CYCLES - 1);

    typedef enum logic {RUN, WIN} state_t;

    // entry: {deferred, addr, data}
    logic [53:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [CW-1:0] win_cnt;
    state_t        state;

    logic [53:0] head;
    logic        push_req;
    logic        pop;
    logic        push_acc;

    assign head     = mem[rd_ptr];
    assign push_req = cpu_cs & cpu_wr;
    // Outside the window a deferred head blocks everything behind it to keep strict order.
    assign pop      = (level != '0) && ((state == WIN) || !head[53]);
    assign push_acc = push_req && ((level != DEPTH_L) || pop);

    assign fifo_level = level;
    assign fifo_full  = (level == DEPTH_L);

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= {defer_en & ~cpu_addr[20], cpu_addr, cpu_wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + {{(LW-1){1'b0}}, push_acc} - {{(LW-1){1'b0}}, pop};
            if (push_req && !push_acc) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_cs      <= 1'b0;
            video_wr      <= 1'b0;
            video_addr    <= '0;
            video_wr_data <= '0;
        end else begin
            video_cs <= pop;
            video_wr <= pop;
            if (pop) begin
                video_addr    <= head[52:32];
                video_wr_data <= head[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            win_cnt   <= '0;
            in_window <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (frame_end) begin
                        state     <= WIN;
                        win_cnt   <= WIN_LOAD;
                        in_window <= 1'b1;
                    end
                end
                WIN: begin
                    if (frame_end) begin
                        win_cnt <= WIN_LOAD;
                    end else if (win_cnt == '0) begin
                        state     <= RUN;
                        in_window <= 1'b0;
                    end else begin
                        win_cnt <= win_cnt - CW'(1);
                    end
                end
                default: begin
                    state     <= RUN;
                    in_window <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_video_wr_scheduler.sv
// tb/tb_video_wr_scheduler.sv - scoreboard bench for video_wr_scheduler
module tb_video_wr_scheduler;
    localparam int DEPTH      = 16;
    localparam int WIN_CYCLES = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_cs = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [20:0] cpu_addr = '0;
    logic [31:0] cpu_wr_data = '0;
    logic        defer_en = 1'b0;
    logic        frame_end = 1'b0;
    logic        clr_overflow = 1'b0;
    logic        video_cs;
    logic        video_wr;
    logic [20:0] video_addr;
    logic [31:0] video_wr_data;
    logic [4:0]  fifo_level;
    logic        fifo_full;
    logic        overflow;
    logic        in_window;

    video_wr_scheduler #(.DEPTH(DEPTH), .WIN_CYCLES(WIN_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_cs(cpu_cs), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .defer_en(defer_en),
        .frame_end(frame_end), .clr_overflow(clr_overflow), .video_cs(video_cs),
        .video_wr(video_wr), .video_addr(video_addr), .video_wr_data(video_wr_data),
        .fifo_level(fifo_level), .fifo_full(fifo_full), .overflow(overflow),
        .in_window(in_window)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats = 0;
    int win_cnt = 0;
    int beat_cyc[$];
    logic [52:0] sb[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: every bus beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_window) win_cnt++;
            if (video_cs) begin
                logic [52:0] e;
                beats++;
                beat_cyc.push_back(cyc);
                chk("video_wr_eq_cs", video_wr, 1'b1);
                chk("beat_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_addr", video_addr, e[52:32]);
                    chk("beat_data", video_wr_data, e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [20:0] a, input logic [31:0] d, input bit acc);
        cpu_cs = 1'b1;
        cpu_wr = 1'b1;
        cpu_addr = a;
        cpu_wr_data = d;
        if (acc) sb.push_back({a, d});
        tick();
        cpu_cs = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (beats >= target) break;
            tick();
        end
        chk(name, beats >= target, 1'b1);
    endtask

    task automatic wait_win_close(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (!in_window) break;
            tick();
        end
        chk(name, in_window, 1'b0);
    endtask

    initial begin
        int base;
        int push_cyc;

        // reset state
        #12;
        chk("rst_video_cs", video_cs, 1'b0);
        chk("rst_video_wr", video_wr, 1'b0);
        chk("rst_video_addr", video_addr, 21'h0);
        chk("rst_video_data", video_wr_data, 32'h0);
        chk("rst_level", fifo_level, 5'd0);
        chk("rst_full_ovf_win", {fifo_full, overflow, in_window}, 3'b000);
        reset_n = 1'b1;
        tick();
        tick();

        // 1: fb write drains with two-cycle latency
        base = beats;
        push_cyc = cyc;
        push(21'h100010, 32'hABC, 1'b1);
        chk("t1_level_after_push", fifo_level, 5'd1);
        wait_beats(base + 1, 10, "t1_beat_timeout");
        chk("t1_latency", beat_cyc[$] - push_cyc, 2);
        tick();
        chk("t1_level_zero", fifo_level, 5'd0);

        // 2: deferred slot write blocks a later fb write until the window
        defer_en = 1'b1;
        base = beats;
        push(21'h000C04, 32'h11, 1'b1);
        push(21'h100000, 32'h22, 1'b1);
        repeat (20) tick();
        chk("t2_no_beat_before_frame", beats, base);
        chk("t2_level_blocked", fifo_level, 5'd2);
        pulse_frame_end();
        wait_beats(base + 2, 10, "t2_beat_timeout");
        chk("t2_consecutive", beat_cyc[$] - beat_cyc[$-1], 1);
        wait_win_close(WIN_CYCLES + 20, "t2_window_close");

        // 3: fill with deferred writes, overflow on the 17th
        base = beats;
        for (int i = 0; i < 17; i++) begin
            push(21'h000200 + 21'(i), 32'h3000 + 32'(i), i < 16);
        end
        chk("t3_level_full", fifo_level, 5'd16);
        chk("t3_full", fifo_full, 1'b1);
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_no_beat", beats, base);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t3_overflow_clr", overflow, 1'b0);

        // 4: push into a full FIFO while the window pops
        win_cnt = 0;
        pulse_frame_end();
        push(21'h100055, 32'h55, 1'b1);
        chk("t4_level_stays", fifo_level, 5'd16);
        chk("t4_overflow_stays0", overflow, 1'b0);
        wait_beats(base + 17, 40, "t4_beat_timeout");
        chk("t4_drain_consecutive", beat_cyc[$] - beat_cyc[$-16], 16);
        wait_win_close(WIN_CYCLES + 20, "t4_window_close");
        chk("t3_window_len", win_cnt, WIN_CYCLES);
        chk("t4_sb_empty", sb.size(), 0);

        // 5: frame_end mid-window reloads, then a deferred write waits for the next window
        win_cnt = 0;
        pulse_frame_end();
        for (int i = 0; i < 600; i++) begin
            if (win_cnt >= 500) break;
            tick();
        end
        pulse_frame_end();
        wait_win_close(WIN_CYCLES + 20, "t5_window_close");
        chk("t5_window_len", win_cnt, 501 + WIN_CYCLES);
        base = beats;
        push(21'h000777, 32'h77, 1'b1);
        repeat (30) tick();
        chk("t5_deferred_blocked", beats, base);
        chk("t5_level", fifo_level, 5'd1);
        pulse_frame_end();
        wait_beats(base + 1, 10, "t5_beat_timeout");
        wait_win_close(WIN_CYCLES + 20, "t5_window_close2");

        // 6: reset mid-drain discards everything
        for (int i = 0; i < 8; i++) begin
            push(21'h000400 + 21'(i), 32'h6000 + 32'(i), 1'b1);
        end
        chk("t6_level8", fifo_level, 5'd8);
        base = beats;
        pulse_frame_end();
        wait_beats(base + 3, 20, "t6_beat_timeout");
        reset_n = 1'b0;
        #1;
        chk("t6_rst_video_cs", video_cs, 1'b0);
        chk("t6_rst_level", fifo_level, 5'd0);
        chk("t6_rst_in_window", in_window, 1'b0);
        sb.delete();
        tick();
        tick();
        reset_n = 1'b1;
        base = beats;
        repeat (10) tick();
        pulse_frame_end();
        repeat (20) tick();
        chk("t6_no_stale_beat", beats, base);
        chk("t6_level_after", fifo_level, 5'd0);
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
